// File: rtl/twitch_core.sv
// twitch_core: multi-cycle RV32I core with a private unified instruction/data memory.
// Every instruction walks the same seven one-hot steps; ECALL/EBREAK/illegal opcodes freeze it.

module twitch_mem #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] mem [0:WORDS-1];

  // NOTE: storage arrays get no reset; contents come from preload and stores only.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (i_we && i_be[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    o_rdata <= mem[i_addr];
  end
endmodule

module twitch_core #(
  parameter int MEM_WORDS = 4096
) (
  input  logic clk,
  input  logic resetn,
  output logic trap
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [6:0] {
    S_FETCH  = 7'b0000001,
    S_LATCH  = 7'b0000010,
    S_DECODE = 7'b0000100,
    S_EXEC   = 7'b0001000,
    S_ADDR   = 7'b0010000,
    S_MEM    = 7'b0100000,
    S_WB     = 7'b1000000
  } step_t;

  step_t       step, w_step_next;
  logic [31:0] regs [0:31];
  logic [31:0] pc, i_data, alu_left, alu_imm, pend, d_addr, d_data;
  logic [6:0]  opcode;
  logic [2:0]  alu_func;
  logic        alu_alt;
  logic [31:0] r_imm, r_rs2;
  logic [4:0]  r_rd;

  logic [4:0]  w_rs1, w_rs2;
  logic [31:0] w_rs1_val, w_rs2_val, w_imm, w_sum, w_alu, w_result, w_pc_next;
  logic [31:0] w_rdata, w_ld_word, w_load_val, w_mem_addr;
  logic [4:0]  w_shamt;
  logic [3:0]  w_be;
  logic        w_cond, w_illegal, w_wb_en, w_we, w_unused;

  assign w_rs1     = i_data[19:15];
  assign w_rs2     = i_data[24:20];
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : regs[w_rs2];
  assign w_sum     = alu_left + alu_imm;
  assign w_shamt   = alu_imm[4:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_imm = {{20{i_data[31]}}, i_data[31:20]};
    case (i_data[6:0])
      OP_STORE:         w_imm = {{20{i_data[31]}}, i_data[31:25], i_data[11:7]};
      OP_BRANCH:        w_imm = {{19{i_data[31]}}, i_data[31], i_data[7], i_data[30:25], i_data[11:8], 1'b0};
      OP_LUI, OP_AUIPC: w_imm = {i_data[31:12], 12'd0};
      OP_JAL:           w_imm = {{11{i_data[31]}}, i_data[31], i_data[19:12], i_data[20], i_data[30:21], 1'b0};
      default:          w_imm = {{20{i_data[31]}}, i_data[31:20]};
    endcase
  end

  always_comb begin
    w_alu = 32'd0;
    case (alu_func)
      3'd0: w_alu = alu_alt ? alu_left - alu_imm : alu_left + alu_imm;
      3'd1: w_alu = alu_left << w_shamt;
      3'd2: w_alu = {31'd0, $signed(alu_left) < $signed(alu_imm)};
      3'd3: w_alu = {31'd0, alu_left < alu_imm};
      3'd4: w_alu = alu_left ^ alu_imm;
      3'd5: w_alu = alu_alt ? 32'($signed(alu_left) >>> w_shamt) : alu_left >> w_shamt;
      3'd6: w_alu = alu_left | alu_imm;
      default: w_alu = alu_left & alu_imm;
    endcase
    w_cond = 1'b0;
    case (alu_func)
      3'd0: w_cond = (alu_left == alu_imm);
      3'd1: w_cond = (alu_left != alu_imm);
      3'd4: w_cond = ($signed(alu_left) <  $signed(alu_imm));
      3'd5: w_cond = ($signed(alu_left) >= $signed(alu_imm));
      3'd6: w_cond = (alu_left <  alu_imm);
      3'd7: w_cond = (alu_left >= alu_imm);
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_result  = 32'd0;
    w_illegal = 1'b0;
    w_wb_en   = 1'b0;
    w_pc_next = pc + 32'd4;
    case (opcode)
      OP_LUI:            begin w_result = alu_imm;        w_wb_en = 1'b1; end
      OP_AUIPC:          begin w_result = pc + alu_imm;   w_wb_en = 1'b1; end
      OP_JAL:            begin w_result = pc + 32'd4;     w_wb_en = 1'b1; w_pc_next = pc + r_imm; end
      OP_JALR:           begin w_result = pc + 32'd4;     w_wb_en = 1'b1; w_pc_next = w_sum & ~32'd1; end
      OP_BRANCH:         begin w_result = {31'd0, w_cond}; if (pend[0]) w_pc_next = pc + r_imm; end
      OP_IMM, OP_OP:     begin w_result = w_alu;          w_wb_en = 1'b1; end
      OP_LOAD:           w_wb_en = 1'b1;
      OP_STORE, OP_FENCE: ;
      OP_SYSTEM:         begin w_illegal = (alu_func == 3'd0); w_wb_en = 1'b1; end
      default:           w_illegal = 1'b1;
    endcase
  end

  // Loaded word is shifted down so the addressed byte lands in bits [7:0].
  assign w_ld_word = w_rdata >> {d_addr[1:0], 3'b000};
  always_comb begin
    w_load_val = w_ld_word;
    case (alu_func)
      3'd0:    w_load_val = {{24{w_ld_word[7]}},  w_ld_word[7:0]};
      3'd1:    w_load_val = {{16{w_ld_word[15]}}, w_ld_word[15:0]};
      3'd4:    w_load_val = {24'd0, w_ld_word[7:0]};
      3'd5:    w_load_val = {16'd0, w_ld_word[15:0]};
      default: w_load_val = w_ld_word;
    endcase
    w_be = 4'b1111;
    case (alu_func[1:0])
      2'd0:    w_be = 4'b0001 << d_addr[1:0];
      2'd1:    w_be = 4'b0011 << d_addr[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  assign w_mem_addr = (step == S_FETCH) ? pc : d_addr;
  assign w_we       = (step == S_MEM) && (opcode == OP_STORE) && !trap;
  assign w_unused   = ^{w_mem_addr[31:AW+2], w_mem_addr[1:0]};

  twitch_mem #(.WORDS(MEM_WORDS), .AW(AW)) r (
    .clk     (clk),
    .i_addr  (w_mem_addr[AW+1:2]),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_wdata (d_data),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_step_next = step;
    if (!trap && !((step == S_EXEC) && w_illegal)) begin
      case (step)
        S_FETCH:  w_step_next = S_LATCH;
        S_LATCH:  w_step_next = S_DECODE;
        S_DECODE: w_step_next = S_EXEC;
        S_EXEC:   w_step_next = S_ADDR;
        S_ADDR:   w_step_next = S_MEM;
        S_MEM:    w_step_next = S_WB;
        default:  w_step_next = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) step <= S_FETCH;
    else        step <= w_step_next;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pc <= '0; i_data <= '0; opcode <= '0; alu_func <= '0; alu_alt <= 1'b0;
      alu_left <= '0; alu_imm <= '0; pend <= '0; d_addr <= '0; d_data <= '0;
      r_imm <= '0; r_rs2 <= '0; r_rd <= '0; trap <= 1'b0;
    end else if (!trap) begin
      case (step)
        S_LATCH: i_data <= w_rdata;
        S_DECODE: begin
          opcode   <= i_data[6:0];
          alu_func <= i_data[14:12];
          alu_left <= w_rs1_val;
          r_rs2    <= w_rs2_val;
          r_imm    <= w_imm;
          r_rd     <= i_data[11:7];
          alu_imm  <= (i_data[6:0] == OP_OP || i_data[6:0] == OP_BRANCH) ? w_rs2_val : w_imm;
          alu_alt  <= (i_data[6:0] == OP_OP ||
                       (i_data[6:0] == OP_IMM && i_data[14:12] == 3'd5)) ? i_data[30] : 1'b0;
        end
        S_EXEC: begin
          if (w_illegal) trap <= 1'b1;
          else           pend <= w_result;
        end
        S_ADDR: begin
          d_addr <= w_sum;
          d_data <= r_rs2 << {w_sum[1:0], 3'b000};
        end
        S_WB:    pc <= w_pc_next;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!trap && step == S_WB && w_wb_en && r_rd != 5'd0)
      regs[r_rd] <= (opcode == OP_LOAD) ? w_load_val : pend;
  end
endmodule

// File: tb/tb_twitch_core.sv
// Directed bench for twitch_core: small hand-assembled programs, expectations worked out by hand.
module tb_twitch_core;
  logic clk = 1'b0;
  logic resetn;
  logic trap;
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [31:0] ECALL   = 32'h00000073;
  localparam logic [31:0] EBREAK  = 32'h00100073;

  twitch_core #(.MEM_WORDS(4096)) dut (.clk(clk), .resetn(resetn), .trap(trap));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic hold_reset();
    resetn = 1'b1;
    for (int i = 0; i < 4096; i++) dut.r.mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.regs[i] = 32'd0;
    @(posedge clk); #1;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.r.mem[idx] = w;
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic run_to_trap(input int limit, output int cycles);
    cycles = 0;
    while (!trap && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
    checks++;
    if (trap !== 1'b1) begin
      errors++;
      $display("FAIL trap_timeout: trap=%b after %0d cycles, required 1", trap, cycles);
    end
  endtask

  task automatic test_reset();
    hold_reset();
    put(0, 32'h00500093);
    put(1, ECALL);
    checks++; if (dut.step !== 7'b0000001) begin errors++; $display("FAIL reset_step: got %b expected 0000001", dut.step); end
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", dut.pc); end
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b expected 0", trap); end
    checks++;
    if ({dut.pend, dut.d_addr, dut.d_data, dut.i_data} !== 128'd0) begin
      errors++; $display("FAIL reset_regs: pend=%h d_addr=%h d_data=%h i_data=%h expected all 0",
                         dut.pend, dut.d_addr, dut.d_data, dut.i_data);
    end
    release_reset();
    @(posedge clk); #1;
    checks++; if (dut.step !== 7'b0000010) begin errors++; $display("FAIL first_fetch_step: got %b expected 0000010", dut.step); end
    repeat (6) @(posedge clk); #1;
    checks++; if (dut.step !== 7'b0000001) begin errors++; $display("FAIL seven_cycle_step: got %b expected 0000001", dut.step); end
    checks++; if (dut.pc !== 32'd4) begin errors++; $display("FAIL seven_cycle_pc: got %h expected 4", dut.pc); end
    checks++; if (dut.regs[1] !== 32'd5) begin errors++; $display("FAIL addi_x1: got %h expected 5", dut.regs[1]); end
    repeat (3) @(posedge clk); #1;
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL trap_early: got %b expected 0 at edge 10", trap); end
    @(posedge clk); #1;
    checks++; if (trap !== 1'b1) begin errors++; $display("FAIL trap_rise: got %b expected 1 at edge 11", trap); end
    repeat (10) @(posedge clk); #1;
    checks++; if (trap !== 1'b1) begin errors++; $display("FAIL trap_sticky: got %b expected 1", trap); end
    checks++; if (dut.pc !== 32'd4) begin errors++; $display("FAIL trap_pc: got %h expected 4", dut.pc); end
    resetn = 1'b1; #1;
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL trap_clear: got %b expected 0", trap); end
  endtask

  task automatic test_lui_add_sub();
    int cyc;
    int          ri [4] = '{2, 3, 4, 5};
    logic [31:0] rv [4] = '{32'h12345678, 32'hEDCBA988, 32'h0000100C, 32'h00000000};
    hold_reset();
    dut.regs[5] = 32'hFFFFFFFF;
    put(0, enc_u(20'h12345, 5'd2, OP_LUI));
    put(1, enc_i(12'h678, 5'd2, 3'd0, 5'd2, OP_IMM));
    put(2, enc_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd3));
    put(3, enc_u(20'h00001, 5'd4, OP_AUIPC));
    put(4, enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd5));
    put(5, ECALL);
    release_reset();
    run_to_trap(400, cyc);
    checks++; if (cyc !== 39) begin errors++; $display("FAIL alu_cycles: got %0d expected 39", cyc); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut.regs[ri[k]] !== rv[k]) begin
        errors++; $display("FAIL alu_x%0d: got %h expected %h", ri[k], dut.regs[ri[k]], rv[k]);
      end
    end
  endtask

  task automatic test_store_load();
    int cyc;
    int          ri [6] = '{5, 6, 7, 8, 9, 10};
    logic [31:0] rv [6] = '{32'hDEADBEEF, 32'hFFFFFFBE, 32'h0000DEAD, 32'hFFFFBEEF, 32'h000000DE, 32'hDEADBEEF};
    hold_reset();
    put(65, 32'h11223344);
    put(66, 32'h55667788);
    put(0,  enc_u(20'hDEADC, 5'd5, OP_LUI));
    put(1,  enc_i(12'hEEF, 5'd5, 3'd0, 5'd5, OP_IMM));
    put(2,  enc_s(12'h100, 5'd5, 5'd0, 3'd2));
    put(3,  enc_i(12'h101, 5'd0, 3'd0, 5'd6, OP_LOAD));
    put(4,  enc_i(12'h102, 5'd0, 3'd5, 5'd7, OP_LOAD));
    put(5,  enc_s(12'h105, 5'd5, 5'd0, 3'd0));
    put(6,  enc_s(12'h10A, 5'd5, 5'd0, 3'd1));
    put(7,  enc_i(12'h10A, 5'd0, 3'd1, 5'd8, OP_LOAD));
    put(8,  enc_i(12'h103, 5'd0, 3'd4, 5'd9, OP_LOAD));
    put(9,  enc_u(20'h80000, 5'd11, OP_LUI));
    put(10, enc_i(12'h100, 5'd11, 3'd2, 5'd10, OP_LOAD));
    put(11, ECALL);
    release_reset();
    run_to_trap(800, cyc);
    checks++; if (cyc !== 81) begin errors++; $display("FAIL mem_cycles: got %0d expected 81", cyc); end
    checks++; if (dut.r.mem[64] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_word: got %h expected deadbeef", dut.r.mem[64]); end
    checks++; if (dut.r.mem[65] !== 32'h1122EF44) begin errors++; $display("FAIL sb_lane1: got %h expected 1122ef44", dut.r.mem[65]); end
    checks++; if (dut.r.mem[66] !== 32'hBEEF7788) begin errors++; $display("FAIL sh_upper: got %h expected beef7788", dut.r.mem[66]); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (dut.regs[ri[k]] !== rv[k]) begin
        errors++; $display("FAIL load_x%0d: got %h expected %h", ri[k], dut.regs[ri[k]], rv[k]);
      end
    end
  endtask

  task automatic test_branch_jump();
    int cyc;
    int          ri [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    logic [31:0] rv [10] = '{32'h0, 32'h14, 32'h1, 32'h0, 32'h0, 32'h20, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h3};
    hold_reset();
    put(0,  enc_i(12'h001, 5'd0, 3'd0, 5'd2, OP_IMM));
    put(1,  enc_b(13'h008, 5'd0, 5'd2, 3'd1));
    put(2,  enc_i(12'h007, 5'd0, 3'd0, 5'd3, OP_IMM));
    put(3,  enc_b(13'h008, 5'd0, 5'd2, 3'd0));
    put(4,  enc_j(21'h000008, 5'd1));
    put(5,  enc_i(12'h009, 5'd0, 3'd0, 5'd4, OP_IMM));
    put(6,  enc_i(12'h001, 5'd0, 3'd0, 5'd0, OP_IMM));
    put(7,  enc_i(12'h025, 5'd0, 3'd0, 5'd5, OP_JALR));
    put(8,  enc_i(12'h001, 5'd0, 3'd0, 5'd6, OP_IMM));
    put(9,  enc_i(12'hFFF, 5'd0, 3'd0, 5'd7, OP_IMM));
    put(10, enc_b(13'h008, 5'd7, 5'd2, 3'd6));
    put(11, enc_i(12'h001, 5'd0, 3'd0, 5'd8, OP_IMM));
    put(12, enc_b(13'h008, 5'd2, 5'd7, 3'd5));
    put(13, enc_i(12'h003, 5'd0, 3'd0, 5'd9, OP_IMM));
    put(14, ECALL);
    release_reset();
    run_to_trap(800, cyc);
    checks++; if (cyc !== 74) begin errors++; $display("FAIL br_cycles: got %0d expected 74", cyc); end
    checks++; if (dut.pc !== 32'h38) begin errors++; $display("FAIL br_pc: got %h expected 38", dut.pc); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (dut.regs[ri[k]] !== rv[k]) begin
        errors++; $display("FAIL br_x%0d: got %h expected %h", ri[k], dut.regs[ri[k]], rv[k]);
      end
    end
  endtask

  task automatic test_shift_compare();
    int cyc;
    int          ri [14] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    logic [31:0] rv [14] = '{32'hF8000000, 32'h08000000, 32'h1, 32'h0, 32'h21, 32'h42, 32'hC0000000,
                             32'h1, 32'h1, 32'hFFFFFFDE, 32'h08000000, 32'h80000021, 32'h40000000, 32'h80000000};
    hold_reset();
    put(0,  enc_u(20'h80000, 5'd1, OP_LUI));
    put(1,  enc_i(12'h404, 5'd1, 3'd5, 5'd2, OP_IMM));
    put(2,  enc_i(12'h004, 5'd1, 3'd5, 5'd3, OP_IMM));
    put(3,  enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd4));
    put(4,  enc_r(7'h00, 5'd0, 5'd1, 3'd3, 5'd5));
    put(5,  enc_i(12'h021, 5'd0, 3'd0, 5'd6, OP_IMM));
    put(6,  enc_r(7'h00, 5'd6, 5'd6, 3'd1, 5'd7));
    put(7,  enc_r(7'h20, 5'd6, 5'd1, 3'd5, 5'd8));
    put(8,  enc_i(12'hFFF, 5'd1, 3'd2, 5'd9, OP_IMM));
    put(9,  enc_i(12'hFFF, 5'd1, 3'd3, 5'd10, OP_IMM));
    put(10, enc_i(12'hFFF, 5'd6, 3'd4, 5'd11, OP_IMM));
    put(11, enc_r(7'h00, 5'd3, 5'd2, 3'd7, 5'd12));
    put(12, enc_r(7'h00, 5'd1, 5'd6, 3'd6, 5'd13));
    put(13, enc_r(7'h00, 5'd6, 5'd1, 3'd5, 5'd14));
    put(14, enc_i(12'h01F, 5'd6, 3'd1, 5'd15, OP_IMM));
    put(15, ECALL);
    release_reset();
    run_to_trap(800, cyc);
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (dut.regs[ri[k]] !== rv[k]) begin
        errors++; $display("FAIL shift_x%0d: got %h expected %h", ri[k], dut.regs[ri[k]], rv[k]);
      end
    end
  endtask

  task automatic test_firmware();
    int cyc;
    int          ri [4] = '{10, 11, 12, 13};
    logic [31:0] rv [4] = '{32'h4F, 32'h4B, 32'h0A, 32'h0};
    hold_reset();
    put(128, 32'h000A4B4F);
    put(0, enc_i(12'h200, 5'd0, 3'd4, 5'd10, OP_LOAD));
    put(1, enc_i(12'h201, 5'd0, 3'd4, 5'd11, OP_LOAD));
    put(2, enc_i(12'h202, 5'd0, 3'd4, 5'd12, OP_LOAD));
    put(3, enc_i(12'h055, 5'd0, 3'd0, 5'd13, OP_IMM));
    put(4, enc_i(12'hB00, 5'd0, 3'd2, 5'd13, OP_SYS));
    put(5, 32'h0FF0000F);
    put(6, 32'h00000000);
    release_reset();
    run_to_trap(800, cyc);
    checks++; if (cyc !== 46) begin errors++; $display("FAIL fw_cycles: got %0d expected 46", cyc); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut.regs[ri[k]] !== rv[k]) begin
        errors++; $display("FAIL fw_x%0d: got %h expected %h", ri[k], dut.regs[ri[k]], rv[k]);
      end
    end
    repeat (20) @(posedge clk); #1;
    checks++; if (dut.pc !== 32'h18) begin errors++; $display("FAIL illegal_pc: got %h expected 18", dut.pc); end
    checks++; if (trap !== 1'b1) begin errors++; $display("FAIL illegal_trap: got %b expected 1", trap); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    hold_reset();
    put(192, 32'h11111111);
    put(0, enc_i(12'h07B, 5'd0, 3'd0, 5'd1, OP_IMM));
    put(1, enc_s(12'h300, 5'd1, 5'd0, 3'd2));
    put(2, EBREAK);
    release_reset();
    repeat (6) @(posedge clk); #1;
    resetn = 1'b1; #1;
    checks++; if (dut.step !== 7'b0000001) begin errors++; $display("FAIL async_step: got %b expected 0000001", dut.step); end
    @(posedge clk); #1;
    checks++; if (dut.regs[1] !== 32'd0) begin errors++; $display("FAIL abort_wb: got %h expected 0", dut.regs[1]); end
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL abort_pc: got %h expected 0", dut.pc); end
    release_reset();
    repeat (12) @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (dut.r.mem[192] !== 32'h11111111) begin errors++; $display("FAIL abort_store: got %h expected 11111111", dut.r.mem[192]); end
    checks++; if (dut.regs[1] !== 32'h7B) begin errors++; $display("FAIL abort_first_wb: got %h expected 7b", dut.regs[1]); end
    release_reset();
    repeat (13) @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (dut.r.mem[192] !== 32'h7B) begin errors++; $display("FAIL committed_store: got %h expected 7b", dut.r.mem[192]); end
    put(192, 32'h11111111);
    release_reset();
    run_to_trap(400, cyc);
    checks++; if (cyc !== 18) begin errors++; $display("FAIL ebreak_cycles: got %0d expected 18", cyc); end
    checks++; if (dut.r.mem[192] !== 32'h7B) begin errors++; $display("FAIL full_store: got %h expected 7b", dut.r.mem[192]); end
    checks++; if (dut.pc !== 32'h8) begin errors++; $display("FAIL ebreak_pc: got %h expected 8", dut.pc); end
  endtask

  initial begin
    test_reset();
    test_lui_add_sub();
    test_store_load();
    test_branch_jump();
    test_shift_compare();
    test_firmware();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
